// File: rtl/parking_pkg.sv
// Shared types and 7-segment glyphs for the parking gate controller.
// The LOCKED state exists only when PARKING_LOCKOUT_EN is defined.
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_WAIT_PASSWORD = 3'd1,
    ST_WRONG_PASS    = 3'd2,
    ST_RIGHT_PASS    = 3'd3,
    ST_STOP          = 3'd4,
    ST_FULL          = 3'd5
`ifdef PARKING_LOCKOUT_EN
    , ST_LOCKED      = 3'd6
`endif
  } state_t;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_G     = SEG_6;
  localparam logic [6:0] SEG_O     = SEG_0;
  localparam logic [6:0] SEG_S     = SEG_5;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_L     = 7'h47;

endpackage

// File: rtl/seg7_digit.sv
// Decimal digit to active-low 7-segment glyph; non-decimal codes blank.
module seg7_digit
  import parking_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] seg
);

  // Pure lookup, no state.
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/parking_controller.sv
// Password-gated parking entrance with occupancy tracking and HEX status.
// Optional: PARKING_LOCKOUT_EN adds a LOCKED state after MAX_TRIES wrong
// submissions, released after LOCK_CYCLES cycles.
module parking_controller
  import parking_pkg::*;
#(
  parameter int               CAPACITY    = 8,
  parameter int               PWD_W       = 4,
  parameter logic [PWD_W-1:0] PASSWORD    = PWD_W'(4'b0110),
  parameter int               WAIT_CYCLES = 50_000_000,
  parameter int               BLINK_BIT   = 25
`ifdef PARKING_LOCKOUT_EN
  , parameter int             MAX_TRIES   = 3,
  parameter int               LOCK_CYCLES = 100_000_000
`endif
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            sensor_entrance,
  input  logic                            sensor_exit,
  input  logic                            sensor_leave,
  input  logic [PWD_W-1:0]                password,
  input  logic                            password_valid,
  output logic                            GREEN_LED,
  output logic                            RED_LED,
  output logic [6:0]                      HEX_1,
  output logic [6:0]                      HEX_2,
  output logic [$clog2(CAPACITY+1)-1:0]   free_count,
  output logic                            full
);

  localparam int                CNT_W    = $clog2(CAPACITY + 1);
  localparam int                TMR_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CAP_V    = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(WAIT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [BLINK_BIT:0] blink_cnt;
  logic               blink;
  logic               leave_q, depart, entry;
  logic               pwd_ok, pwd_bad;
  logic [3:0]         tens_v, ones_v;
  logic [6:0]         tens_seg, ones_seg;
  logic               green_d, red_d;
  logic [6:0]         hex1_d, hex2_d;

`ifdef PARKING_LOCKOUT_EN
  localparam int               TRY_W     = $clog2(MAX_TRIES + 1);
  localparam int               LCK_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST  = TRY_W'(MAX_TRIES - 1);
  localparam logic [LCK_W-1:0] LOCK_LAST = LCK_W'(LOCK_CYCLES - 1);
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [LCK_W-1:0] lock_q, lock_d;
  logic             last_try;
  assign last_try = (tries_q == TRY_LAST);
`endif

  assign pwd_ok  = password_valid && (password == PASSWORD);
  assign pwd_bad = password_valid && (password != PASSWORD);
  assign depart  = sensor_leave && !leave_q;
  assign full    = (free_count == '0);
  assign blink   = blink_cnt[BLINK_BIT];
  assign tens_v  = 4'(int'(free_count) / 10);
  assign ones_v  = 4'(int'(free_count) % 10);

  seg7_digit u_tens (.value(tens_v), .seg(tens_seg));
  seg7_digit u_ones (.value(ones_v), .seg(ones_seg));

  // Next state, password timer, retry bookkeeping and entry event.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    entry   = 1'b0;
`ifdef PARKING_LOCKOUT_EN
    tries_d = tries_q;
    lock_d  = lock_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (sensor_entrance) begin
          if (full) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_WAIT_PASSWORD;
            tmr_d   = '0;
          end
        end
      end
      ST_WAIT_PASSWORD: begin
        tmr_d = tmr_q + 1'b1;
        // A submission on the final cycle takes priority over the timeout.
        if (pwd_ok) begin
          state_d = ST_RIGHT_PASS;
        end else if (pwd_bad) begin
          state_d = ST_WRONG_PASS;
`ifdef PARKING_LOCKOUT_EN
          tries_d = tries_q + 1'b1;
          if (last_try) begin
            state_d = ST_LOCKED;
            lock_d  = '0;
          end
`endif
        end else if (tmr_q == TMR_LAST) begin
          state_d = ST_IDLE;
        end
      end
      ST_WRONG_PASS: begin
        if (pwd_ok) begin
          state_d = ST_RIGHT_PASS;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end else if (pwd_bad) begin
`ifdef PARKING_LOCKOUT_EN
          tries_d = tries_q + 1'b1;
          if (last_try) begin
            state_d = ST_LOCKED;
            lock_d  = '0;
          end
`endif
        end else if (!sensor_entrance) begin
          state_d = ST_IDLE;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end
      end
      ST_RIGHT_PASS: begin
        if (sensor_entrance && sensor_exit) begin
          state_d = ST_STOP;
        end else if (sensor_exit) begin
          state_d = ST_IDLE;
          entry   = 1'b1;
`ifdef PARKING_LOCKOUT_EN
          tries_d = '0;
`endif
        end
      end
      ST_STOP: begin
        if (pwd_ok) state_d = ST_RIGHT_PASS;
      end
      ST_FULL: begin
        // Freed slots are only noticed after the car backs away.
        if (!sensor_entrance) state_d = ST_IDLE;
      end
`ifdef PARKING_LOCKOUT_EN
      ST_LOCKED: begin
        lock_d = lock_q + 1'b1;
        if (lock_q == LOCK_LAST) begin
          state_d = ST_IDLE;
          tries_d = '0;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
`ifdef PARKING_LOCKOUT_EN
      tries_q <= '0;
      lock_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
`ifdef PARKING_LOCKOUT_EN
      tries_q <= tries_d;
      lock_q  <= lock_d;
`endif
    end
  end

  // Saturating free-slot counter; simultaneous entry and departure cancel.
  always_ff @(posedge clk) begin
    if (reset) begin
      free_count <= CAP_V;
      leave_q    <= 1'b0;
    end else begin
      leave_q <= sensor_leave;
      if (entry && !depart) begin
        if (free_count != '0) free_count <= free_count - 1'b1;
      end else if (depart && !entry) begin
        if (free_count < CAP_V) free_count <= free_count + 1'b1;
      end
    end
  end

  // Free-running blink source.
  always_ff @(posedge clk) begin
    if (reset) blink_cnt <= '0;
    else       blink_cnt <= blink_cnt + 1'b1;
  end

  // Moore output decode from the current state.
  always_comb begin
    green_d = 1'b0;
    red_d   = 1'b0;
    hex1_d  = SEG_BLANK;
    hex2_d  = SEG_BLANK;
    case (state_q)
      ST_IDLE: begin
        hex1_d = (tens_v == 4'd0) ? SEG_BLANK : tens_seg;
        hex2_d = ones_seg;
      end
      ST_WAIT_PASSWORD: begin red_d = 1'b1;  hex1_d = SEG_E; hex2_d = SEG_N; end
      ST_WRONG_PASS:    begin red_d = blink; hex1_d = SEG_E; hex2_d = SEG_E; end
      ST_RIGHT_PASS:    begin green_d = blink; hex1_d = SEG_G; hex2_d = SEG_O; end
      ST_STOP:          begin red_d = blink; hex1_d = SEG_S; hex2_d = SEG_P; end
      ST_FULL:          begin red_d = 1'b1;  hex1_d = SEG_F; hex2_d = SEG_L; end
`ifdef PARKING_LOCKOUT_EN
      ST_LOCKED:        begin red_d = 1'b1;  hex1_d = SEG_L; hex2_d = SEG_O; end
`endif
      default: ;
    endcase
  end

  // Registered outputs, one cycle behind the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      GREEN_LED <= 1'b0;
      RED_LED   <= 1'b0;
      HEX_1     <= SEG_BLANK;
      HEX_2     <= SEG_BLANK;
    end else begin
      GREEN_LED <= green_d;
      RED_LED   <= red_d;
      HEX_1     <= hex1_d;
      HEX_2     <= hex2_d;
    end
  end

endmodule

// File: tb/tb_parking_controller.sv
// Directed + randomized bench for parking_controller with a cycle-level
// behavioural model of the gate rules, occupancy and display messages.
module tb_parking_controller;

  localparam int         CAP   = 2;
  localparam int         WAITC = 10;
  localparam int         BB    = 1;
  localparam logic [3:0] PWD   = 4'b0110;
  localparam logic [3:0] BADPW = 4'b0111;
  localparam int         MT    = 3;
  localparam int         LC    = 20;
`ifdef PARKING_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  localparam int M_IDLE = 0, M_WAIT = 1, M_WRONG = 2, M_RIGHT = 3,
                 M_STOP = 4, M_FULL = 5, M_LOCK = 6;

  logic clk = 1'b0;
  logic reset, se, sx, sl, pv;
  logic [3:0] pw;
  logic g, r, fl;
  logic [6:0] h1, h2;
  logic [$clog2(CAP+1)-1:0] fc;

  int checks = 0;
  int errors = 0;

  // Glyph tables, active-low {g..a}.
  logic [6:0] dig [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] GE = 7'h06, GN = 7'h2B, GP = 7'h0C, GF = 7'h0E,
                         GL = 7'h47, GBL = 7'h7F;

  always #5 clk = ~clk;

  parking_controller #(
    .CAPACITY(CAP), .PWD_W(4), .PASSWORD(PWD), .WAIT_CYCLES(WAITC), .BLINK_BIT(BB)
`ifdef PARKING_LOCKOUT_EN
    , .MAX_TRIES(MT), .LOCK_CYCLES(LC)
`endif
  ) dut (
    .clk(clk), .reset(reset), .sensor_entrance(se), .sensor_exit(sx),
    .sensor_leave(sl), .password(pw), .password_valid(pv),
    .GREEN_LED(g), .RED_LED(r), .HEX_1(h1), .HEX_2(h2),
    .free_count(fc), .full(fl)
  );

  // Reference model state
  int   m_st, m_free, m_wait, m_tries, m_lock, m_cyc;
  bit   m_prev;
  logic m_g, m_r;
  logic [6:0] m_h1, m_h2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int on_wrong();
    m_tries++;
    if (LOCKOUT && m_tries >= MT) begin
      m_lock = 0;
      return M_LOCK;
    end
    return M_WRONG;
  endfunction

  // Advance the model across one clock edge using the current inputs.
  task automatic model_step();
    bit blink, good, bad, dep, ent;
    int nx;
    if (reset) begin
      m_st = M_IDLE; m_free = CAP; m_wait = 0; m_tries = 0; m_lock = 0;
      m_cyc = 0; m_prev = 1'b0; m_g = 1'b0; m_r = 1'b0; m_h1 = GBL; m_h2 = GBL;
      return;
    end
    blink = ((m_cyc >> BB) & 1) != 0;
    m_g = 1'b0; m_r = 1'b0; m_h1 = GBL; m_h2 = GBL;
    case (m_st)
      M_IDLE:  begin m_h1 = (m_free >= 10) ? dig[m_free / 10] : GBL; m_h2 = dig[m_free % 10]; end
      M_WAIT:  begin m_r = 1'b1;  m_h1 = GE;     m_h2 = GN;     end
      M_WRONG: begin m_r = blink; m_h1 = GE;     m_h2 = GE;     end
      M_RIGHT: begin m_g = blink; m_h1 = dig[6]; m_h2 = dig[0]; end
      M_STOP:  begin m_r = blink; m_h1 = dig[5]; m_h2 = GP;     end
      M_FULL:  begin m_r = 1'b1;  m_h1 = GF;     m_h2 = GL;     end
      M_LOCK:  begin m_r = 1'b1;  m_h1 = GL;     m_h2 = dig[0]; end
      default: ;
    endcase
    good = pv && (pw == PWD);
    bad  = pv && (pw != PWD);
    dep  = sl && !m_prev;
    ent  = 1'b0;
    nx   = m_st;
    case (m_st)
      M_IDLE:  if (se) begin
                 if (m_free == 0) nx = M_FULL;
                 else begin nx = M_WAIT; m_wait = 0; end
               end
      M_WAIT:  begin
                 if (good) nx = M_RIGHT;
                 else if (bad) nx = on_wrong();
                 else if (m_wait == WAITC - 1) nx = M_IDLE;
                 m_wait++;
               end
      M_WRONG: if (good) begin nx = M_RIGHT; m_tries = 0; end
               else if (bad) nx = on_wrong();
               else if (!se) begin nx = M_IDLE; m_tries = 0; end
      M_RIGHT: if (se && sx) nx = M_STOP;
               else if (sx) begin nx = M_IDLE; ent = 1'b1; m_tries = 0; end
      M_STOP:  if (good) nx = M_RIGHT;
      M_FULL:  if (!se) nx = M_IDLE;
      M_LOCK:  begin
                 m_lock++;
                 if (m_lock == LC) begin nx = M_IDLE; m_tries = 0; end
               end
      default: nx = M_IDLE;
    endcase
    if (ent && !dep) begin
      if (m_free > 0) m_free--;
    end else if (dep && !ent) begin
      if (m_free < CAP) m_free++;
    end
    m_st   = nx;
    m_prev = sl;
    m_cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("GREEN_LED",  16'(g),  16'(m_g));
    check("RED_LED",    16'(r),  16'(m_r));
    check("HEX_1",      16'(h1), 16'(m_h1));
    check("HEX_2",      16'(h2), 16'(m_h2));
    check("free_count", 16'(fc), 16'(m_free));
    check("full",       16'(fl), 16'(m_free == 0));
  endtask

  task automatic strobe(input logic [3:0] val);
    pv = 1'b1; pw = val;
    tick();
    pv = 1'b0;
  endtask

  initial begin
    int red_cnt, lo_cnt;
    bit saw_hi, saw_lo;
    reset = 1'b1; se = 0; sx = 0; sl = 0; pv = 0; pw = '0;

    // Reset state
    tick(); tick();
    check("rst_free", 16'(fc), 16'(CAP));
    check("rst_hex1", 16'(h1), 16'(GBL));
    check("rst_hex2", 16'(h2), 16'(GBL));
    check("rst_leds", 16'({g, r}), 16'(0));
    reset = 1'b0;
    tick();

    // Correct password on the third waiting cycle, then drive in
    se = 1; tick(); tick(); tick();
    strobe(PWD);
    saw_hi = 0; saw_lo = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (g) saw_hi = 1; else saw_lo = 1;
    end
    check("green_blinks", 16'({saw_hi, saw_lo}), 16'(2'b11));
    se = 0; sx = 1; tick();
    sx = 0; tick(); tick();
    check("entry_free", 16'(fc), 16'(1));
    check("entry_hex2", 16'(h2), 16'(7'h79));

    // Password timeout
    se = 1; tick();
    se = 0;
    red_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (r) red_cnt++;
    end
    check("timeout_red_cycles", 16'(red_cnt), 16'(WAITC));
    check("timeout_free", 16'(fc), 16'(1));

    // Fill the lot, then FULL
    se = 1; tick();
    strobe(PWD);
    se = 0; sx = 1; tick();
    sx = 0; tick();
    se = 1; tick(); tick(); tick();
    check("full_flag", 16'(fl), 16'(1));
    check("full_msg", 16'({h1, h2}), 16'({GF, GL}));
    sl = 1; tick(); tick();
    check("full_leave_free", 16'(fc), 16'(1));
    check("full_stays", 16'(h1), 16'(GF));
    se = 0; tick(); tick(); tick();
    check("full_back_idle", 16'(h2), 16'(7'h79));
    sl = 0; tick();

    // Tailgate -> STOP, wrong stays, correct resumes
    se = 1; tick();
    strobe(PWD);
    sx = 1; tick();
    sx = 0; tick(); tick();
    check("stop_msg", 16'({h1, h2}), 16'({7'h12, GP}));
    strobe(BADPW); tick();
    check("stop_wrong_stays", 16'({h1, h2}), 16'({7'h12, GP}));
    strobe(PWD); tick(); tick();
    check("stop_resume_go", 16'({h1, h2}), 16'({7'h02, 7'h40}));

    // Entry and departure in the same cycle, and saturation at CAPACITY
    se = 0; sx = 1; sl = 1; tick();
    sx = 0; sl = 0; tick();
    check("same_cycle_free", 16'(fc), 16'(1));
    sl = 1; tick(); sl = 0; tick();
    sl = 1; tick(); sl = 0; tick();
    check("leave_saturate", 16'(fc), 16'(CAP));

`ifdef PARKING_LOCKOUT_EN
    // Lockout after three wrong submissions
    se = 1; tick();
    strobe(BADPW); tick();
    strobe(BADPW); tick();
    strobe(BADPW);
    se = 0;
    lo_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 4) begin pv = 1; pw = PWD; end
      else pv = 0;
      tick();
      if (h1 == GL && h2 == 7'h40) lo_cnt++;
    end
    pv = 0;
    check("lock_cycles", 16'(lo_cnt), 16'(LC));
    check("lock_release_idle", 16'(h2), 16'(dig[CAP]));

    // Reset in the middle of a lockout
    se = 1; tick();
    strobe(BADPW); tick();
    strobe(BADPW); tick();
    strobe(BADPW);
    se = 0; tick(); tick(); tick();
    check("lock_msg", 16'({h1, h2}), 16'({GL, 7'h40}));
    reset = 1; tick();
    reset = 0;
    check("lock_rst_hex", 16'({h1, h2}), 16'({GBL, GBL}));
    check("lock_rst_free", 16'(fc), 16'(CAP));
    check("lock_rst_red", 16'(r), 16'(0));
    tick();
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 99) < 15) se = ~se;
      sx = ($urandom_range(0, 99) < 20);
      if ($urandom_range(0, 99) < 25) sl = ~sl;
      pv = ($urandom_range(0, 99) < 20);
      pw = ($urandom_range(0, 1) == 0) ? PWD : 4'($urandom_range(0, 15));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
